// File: rtl/id_ex_pipe_buf.sv
// ID->EX pipeline buffer: DEPTH-entry FIFO with valid/ready on both sides,
// load-use hazard detection over int/float register files, flush, hold and a bubble payload.
module id_ex_pipe_buf #(
    parameter int                   PAYLOAD_W = 160,
    parameter int                   DEPTH     = 2,
    parameter int                   REG_AW    = 5,
    parameter logic [PAYLOAD_W-1:0] BUBBLE    = '0,
    parameter int                   CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PAYLOAD_W-1:0]         in_payload,
    input  logic [REG_AW-1:0]            in_rs1,
    input  logic [REG_AW-1:0]            in_rs2,
    input  logic                         in_use_rs1,
    input  logic                         in_use_rs2,
    input  logic                         in_rs1_f,
    input  logic                         in_rs2_f,
    input  logic                         ex_memread,
    input  logic [REG_AW-1:0]            ex_rd,
    input  logic                         ex_rd_f,
    input  logic                         flush,
    input  logic                         hold,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PAYLOAD_W-1:0]         out_payload,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         hazard_stall,
    output logic [CNT_W-1:0]             bubble_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [PAYLOAD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 enq;
    logic                 deq;
    logic                 rs1_hit;
    logic                 rs2_hit;
    logic                 ex_is_x0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Integer x0 is hardwired to zero so a load into it never creates a dependency; f0 is a real register.
    assign ex_is_x0 = (ex_rd == '0) && !ex_rd_f;
    assign rs1_hit  = in_use_rs1 && (in_rs1 == ex_rd) && (in_rs1_f == ex_rd_f);
    assign rs2_hit  = in_use_rs2 && (in_rs2 == ex_rd) && (in_rs2_f == ex_rd_f);

    assign hazard_stall = rst && in_valid && ex_memread && (rs1_hit || rs2_hit) && !ex_is_x0;

    // in_ready looks only at the registered count, so a full buffer never accepts even when EX pops.
    assign in_ready    = rst && !flush && !hold && !hazard_stall && (occupancy < OCC_W'(DEPTH));
    assign out_valid   = rst && (occupancy != '0) && !hold;
    assign out_payload = out_valid ? mem[rd_ptr] : BUBBLE;

    assign enq = in_valid && in_ready;
    assign deq = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= in_payload;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            bubble_cnt <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (!hold) begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
            if (hazard_stall) begin
                bubble_cnt <= sat_inc(bubble_cnt);
            end
        end
    end

endmodule
